// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite master turning cmd_* requests into AXI transactions and rsp_* results.
// Ports: aclk/areset (async, active-high); cmd_valid/ready/write/addr/wdata/wstrb in;
// rsp_valid/ready/write/rdata/resp/timeout out; AXI4-Lite AW/W/B/AR/R master channels.
// Optional macro AXI4L_MST_TIMEOUT_EN: aborts a transaction after TIMEOUT_CYCLES active cycles.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t                state_q;
  logic                  cmd_ready_q, write_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [1:0]            resp_q;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`ifdef AXI4L_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
`ifdef AXI4L_MST_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && cmd_valid) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            rdata_q     <= '0;
            awvalid_q   <= cmd_write;
            wvalid_q    <= cmd_write;
            arvalid_q   <= !cmd_write;
            state_q     <= cmd_write ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready) wvalid_q <= 1'b0;
          // AW and W complete independently; move on once neither is still pending
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            resp_q      <= bresp;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rdata_q     <= rdata;
            resp_q      <= rresp;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef AXI4L_MST_TIMEOUT_EN
      // Counter rests at zero outside the active states, so it starts fresh at every accept
      cnt_q <= (state_q == IDLE || state_q == DONE) ? '0 : cnt_q + 1'b1;
      if (state_q == DONE && rsp_ready) timeout_q <= 1'b0;
      // Abort overrides whatever the channel logic above decided this cycle
      if (state_q != IDLE && state_q != DONE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rdata_q     <= '0;
        resp_q      <= 2'b10;
        timeout_q   <= 1'b1;
        rsp_valid_q <= 1'b1;
        state_q     <= DONE;
      end
`endif
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: randomized and directed checks of axi4_lite_master against a transaction-level model.
module tb_axi4_lite_master;
  logic        aclk = 1'b0, areset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [31:0] rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  int n_vec = 0, n_err = 0, cyc = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (awvalid && awready) n_aw <= n_aw + 1;
    if (wvalid && wready) n_w <= n_w + 1;
    if (bvalid && bready) n_b <= n_b + 1;
    if (arvalid && arready) n_ar <= n_ar + 1;
    if (rvalid && rready) n_r <= n_r + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output int c0);
    @(negedge aclk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; c0 = cyc;
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic aw_beat(input logic [31:0] addr, input int d);
    for (int t = 0; t < 64 && !awvalid; t++) @(negedge aclk);
    check("awvalid_up", awvalid, 1);
    for (int i = 0; i < d; i++) begin
      check("awaddr_hold", {awvalid, awprot, awaddr}, {1'b1, 3'b000, addr});
      @(negedge aclk);
    end
    check("awaddr", {awprot, awaddr}, {3'b000, addr});
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    check("awvalid_drop", awvalid, 0);
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input int d);
    for (int t = 0; t < 64 && !wvalid; t++) @(negedge aclk);
    check("wvalid_up", wvalid, 1);
    for (int i = 0; i < d; i++) begin
      check("wdata_hold", {wvalid, wstrb, wdata}, {1'b1, strb, data});
      @(negedge aclk);
    end
    check("wdata", {wstrb, wdata}, {strb, data});
    wready = 1'b1;
    @(negedge aclk);
    wready = 1'b0;
    check("wvalid_drop", wvalid, 0);
  endtask

  task automatic ar_beat(input logic [31:0] addr, input int d);
    for (int t = 0; t < 64 && !arvalid; t++) @(negedge aclk);
    check("arvalid_up", arvalid, 1);
    for (int i = 0; i < d; i++) begin
      check("araddr_hold", {arvalid, arprot, araddr}, {1'b1, 3'b000, addr});
      @(negedge aclk);
    end
    check("araddr", {arprot, araddr}, {3'b000, addr});
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    check("arvalid_drop", arvalid, 0);
  endtask

  task automatic b_beat(input logic [1:0] r, input int d);
    for (int t = 0; t < 64 && !bready; t++) @(negedge aclk);
    check("bready_up", bready, 1);
    repeat (d) @(negedge aclk);
    bvalid = 1'b1; bresp = r;
    @(negedge aclk);
    bvalid = 1'b0; bresp = 2'($urandom);
  endtask

  task automatic r_beat(input logic [1:0] r, input logic [31:0] data, input int d);
    for (int t = 0; t < 64 && !rready; t++) @(negedge aclk);
    check("rready_up", rready, 1);
    repeat (d) @(negedge aclk);
    rvalid = 1'b1; rresp = r; rdata = data;
    @(negedge aclk);
    rvalid = 1'b0; rresp = 2'($urandom); rdata = $urandom;
  endtask

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input int d1, input int d2, input int d3, input logic [1:0] resp,
                     input logic [31:0] rd, input int hold, input bit lat);
    int c0, aw0, w0, b0, ar0, r0;
    logic [35:0] exp;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    exp = {wr, resp, 1'b0, wr ? 32'h0 : rd};
    issue(wr, addr, data, strb, c0);
    if (wr) begin
      fork
        aw_beat(addr, d1);
        w_beat(data, strb, d2);
      join
      b_beat(resp, d3);
    end else begin
      ar_beat(addr, d1);
      r_beat(resp, rd, d3);
    end
    for (int t = 0; t < 64 && !rsp_valid; t++) @(negedge aclk);
    check("rsp_valid", rsp_valid, 1);
    if (lat) check("latency", 64'(cyc - c0), 3);
    check("rsp", {rsp_write, rsp_resp, rsp_timeout, rsp_rdata}, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check("rsp_hold", {cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata}, {2'b01, exp});
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("beats", {4'(n_aw - aw0), 4'(n_w - w0), 4'(n_b - b0), 4'(n_ar - ar0), 4'(n_r - r0)},
          {4'(wr), 4'(wr), 4'(wr), 4'(!wr), 4'(!wr)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    #1 areset = 1'b1;
    #2;
    check("rst_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}, 0);
    check("rst_addr", {awaddr, araddr}, 0);
    check("rst_data", {wstrb, wdata, rsp_rdata}, 0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    #1 check("cmd_ready_pre_edge", cmd_ready, 0);
    @(negedge aclk);
    check("cmd_ready_post_rst", cmd_ready, 1);

    txn(1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, 1'b1);
    txn(1'b1, 32'h0000_0020, 32'h1357_9BDF, 4'h5, 4, 0, 1, 2'b00, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h0000_001C, 32'h0, 4'h0, 5, 0, 0, 2'b00, 32'h0001_0000, 0, 1'b0);
    txn(1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, 0, 0, 1, 2'b10, 32'hA5A5_0F0F, 3, 1'b0);
    txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h8000_0001, 0, 1'b1);
    for (int k = 0; k < 40; k++)
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 4)), 2'($urandom), $urandom, int'($urandom_range(0, 3)), 1'b0);

    issue(1'b1, 32'h0000_0040, 32'h0000_1234, 4'h3, c0);
    fork
      aw_beat(32'h0000_0040, 0);
      w_beat(32'h0000_1234, 4'h3, 0);
    join
`ifdef AXI4L_MST_TIMEOUT_EN
    for (int t = 0; t < 64 && !rsp_valid; t++) @(negedge aclk);
    check("to_latency", 64'(cyc - c0), 17);
    check("to_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata, bready}, {1'b1, 1'b1, 2'b10, 1'b1, 32'h0, 1'b0});
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("to_done", {rsp_valid, rsp_timeout, cmd_ready}, 3'b001);
`else
    repeat (40) @(negedge aclk);
    check("no_to_wait", {bready, rsp_valid, rsp_timeout, cmd_ready}, 4'b1000);
    #2 areset = 1'b1;
    #1 check("rst_wr_resp", {bready, rsp_valid, cmd_ready}, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("cmd_ready_rel1", cmd_ready, 1);
`endif

    issue(1'b0, 32'h0000_0024, 32'h0, 4'h0, c0);
    ar_beat(32'h0000_0024, 1);
    for (int t = 0; t < 64 && !rready; t++) @(negedge aclk);
    check("rd_resp_rready", rready, 1);
    #2 areset = 1'b1;
    #1 check("rst_rd_resp", {arvalid, rready, rsp_valid, cmd_ready}, 0);
    @(negedge aclk);
    areset = 1'b0;
    check("cmd_ready_in_rst", cmd_ready, 0);
    @(negedge aclk);
    check("cmd_ready_rel2", cmd_ready, 1);
    repeat (3) begin
      @(negedge aclk);
      check("no_rsp_after_rst", {rsp_valid, arvalid, rready}, 0);
    end
    txn(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hC, 1, 2, 0, 2'b01, 32'h0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
- REQ-001: Parameter ADDR_WIDTH, default 32, AXI address width.
- REQ-002: Parameter DATA_WIDTH, default 32, AXI data width; STRB_WIDTH = DATA_WIDTH/8.
- REQ-003: Parameter TIMEOUT_CYCLES, default 256, response timeout limit (used only with AXI4L_MST_TIMEOUT_EN).
- REQ-004: aclk  in  1  single clock; all logic SHALL be rising-edge.
- REQ-005: areset  in  1  asynchronous, active-high reset.
- REQ-006: cmd_valid / cmd_ready  in / out  1  command handshake.
- REQ-007: cmd_write  in  1  1 = write, 0 = read.
- REQ-008: cmd_addr  in  ADDR_WIDTH  target address.
- REQ-009: cmd_wdata / cmd_wstrb  in  DATA_WIDTH / STRB_WIDTH  write data and strobes (ignored for reads).
- REQ-010: rsp_valid / rsp_ready  out / in  1  response handshake.
- REQ-011: rsp_write  out  1  echoes cmd_write of the completed transaction.
- REQ-012: rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- REQ-013: rsp_resp  out  2  BRESP/RRESP of the transaction.
- REQ-014: rsp_timeout  out  1  transaction aborted by timeout.
- REQ-015: Master-side AXI4-Lite ports awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready, with AXI4-Lite widths and directions.

Function
- REQ-016: FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- REQ-017: cmd_ready SHALL be 1 only in IDLE; one outstanding transaction maximum.
- REQ-018: On cmd handshake, address, data, strobe, and direction SHALL be registered; next state WR_REQ (write) or RD_REQ (read).
- REQ-019: In WR_REQ, awvalid and wvalid SHALL both be asserted starting the cycle after cmd acceptance; each SHALL drop the cycle after its own handshake, in either order or the same cycle.
- REQ-020: awaddr, wdata, and wstrb SHALL stay stable while the corresponding valid is high.
- REQ-021: After both AW and W have been accepted, the FSM SHALL enter WR_RESP with bready=1; on bvalid&&bready it SHALL capture bresp and enter DONE.
- REQ-022: In RD_REQ, arvalid SHALL be 1 until arready; then RD_RESP with rready=1; on rvalid&&rready it SHALL capture rdata and rresp and enter DONE.
- REQ-023: awprot and arprot SHALL be constant 3'b000.
- REQ-024: In DONE, rsp_valid SHALL be 1 and all rsp_* SHALL be stable until rsp_ready; on handshake the FSM SHALL return to IDLE.
- REQ-025: Minimum latency with zero-wait slave: cmd accept at cycle 0, AW/W handshake at cycle 1, B/R handshake at cycle 2, rsp_valid at cycle 3.
- REQ-026: A valid SHALL never depend combinationally on the corresponding ready; all AXI outputs SHALL be registered.

Reset
- REQ-027: While areset=1, all valids, bready, rready, rsp_valid, and rsp_timeout SHALL be 0; cmd_ready SHALL be 1 only after reset release; all data/addr outputs SHALL be 0; the FSM SHALL be in IDLE.
- REQ-028: Reset mid-transaction SHALL abandon it immediately with no response generated.

Configuration
- REQ-029: With `AXI4L_MST_TIMEOUT_EN` defined, a counter SHALL clear on cmd accept and increment each cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP; on reaching TIMEOUT_CYCLES the FSM SHALL deassert all AXI valids and readies and enter DONE with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
- REQ-030: Without `AXI4L_MST_TIMEOUT_EN`, no counter SHALL exist, rsp_timeout SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
- REQ-031: Write 0x0000_0018 / 0xDEAD_BEEF / strb 0xF to a zero-wait slave -> single AW and W beat with those values, rsp_valid at cycle 3, rsp_resp=00, rsp_write=1.
- REQ-032: Slave accepts W 4 cycles before AW -> wvalid drops after its handshake, awvalid held stable until accepted, exactly one B accepted.
- REQ-033: Read 0x0000_001C, slave returns 0x0001_0000 after 5-cycle arready delay -> rsp_rdata=0x0001_0000, rsp_resp=00, araddr stable throughout.
- REQ-034: Read of an unmapped address with rresp=10 and rsp_ready held 0 for 3 cycles -> rsp held stable, rsp_resp=10, cmd_ready=0 until rsp handshake.
- REQ-035: With macro, TIMEOUT_CYCLES=16 and a slave that never asserts bvalid -> at cycle 16 bready drops, rsp_timeout=1, rsp_resp=10; without macro, the FSM stays in WR_RESP.
- REQ-036: Assert areset during RD_RESP -> arvalid, rready, and rsp_valid are 0 asynchronously, and cmd_ready=1 the cycle after release.
